// File: rtl/sine_dds_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel sine DDS generator.
package sine_dds_pkg;

  function automatic int unsigned mid_val(int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

  // One full sine period: round(MID + (MID-1) * sin(2*pi*k/DEPTH)); all entries are positive.
  function automatic int lut_entry(int unsigned k, int unsigned data_w, int unsigned addr_w);
    real mid;
    real ang;
    mid = real'(mid_val(data_w));
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(32'd1 << addr_w);
    return $rtoi(mid + (mid - 1.0) * $sin(ang) + 0.5);
  endfunction

  function automatic int unsigned ch_sel_w(int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sine_lut_rom.sv
// Full-period sine table with a single registered read port; contents fixed at elaboration.
module sine_lut_rom import sine_dds_pkg::*; #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_val(DATA_W));

  logic [DATA_W-1:0] lut_rom [DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    assign lut_rom[k] = DATA_W'(lut_entry(k, DATA_W, ADDR_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= MID;
    end else if (en) begin
      data_q <= lut_rom[addr];
    end
  end

  assign data = data_q;

endmodule

// File: rtl/sine_dds_gen.sv
// Multi-channel sine DDS: shared phase accumulator, per-channel phase offset and
// amplitude shift, reconfigured through a single shadow register at accumulator wrap.
module sine_dds_gen import sine_dds_pkg::*; #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned NUM_CH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [PHASE_W-1:0]           ftw,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ch_sel_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [ADDR_W-1:0]            cfg_phase,
  input  logic [2:0]                   cfg_shift,
  output logic [NUM_CH*DATA_W-1:0]     sample_out,
  output logic                         sample_valid,
  output logic                         wrap
);

  localparam int unsigned CH_W = ch_sel_w(NUM_CH);
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_val(DATA_W));

  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W:0]   sum;
  logic               wrap_q;
  logic               v1_q;
  logic               valid_q;

  logic               pend_q;
  logic [CH_W-1:0]    pend_ch_q;
  logic [ADDR_W-1:0]  pend_phase_q;
  logic [2:0]         pend_shift_q;
  logic               accept;
  logic               apply;

  logic [ADDR_W-1:0]  phase_off_q [NUM_CH];
  logic [2:0]         shift_q     [NUM_CH];

  assign sum = {1'b0, acc_q} + {1'b0, ftw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      wrap_q  <= 1'b0;
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wrap_q  <= en & sum[PHASE_W];
      v1_q    <= en;
      valid_q <= v1_q;
      if (en) begin
        acc_q <= sum[PHASE_W-1:0];
      end
    end
  end

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & ~pend_q;
  // While stopped there is no wrap to wait for, so apply straight away.
  assign apply     = pend_q & (wrap_q | ~en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
      pend_phase_q <= '0;
      pend_shift_q <= '0;
    end else if (accept) begin
      pend_q       <= 1'b1;
      pend_ch_q    <= cfg_ch;
      pend_phase_q <= cfg_phase;
      pend_shift_q <= cfg_shift;
    end else if (apply) begin
      pend_q <= 1'b0;
    end
  end

  // A channel number with no matching channel clears the shadow without touching anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        phase_off_q[c] <= '0;
        shift_q[c]     <= '0;
      end
    end else if (apply) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (pend_ch_q == CH_W'(c)) begin
          phase_off_q[c] <= pend_phase_q;
          shift_q[c]     <= pend_shift_q;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ADDR_W-1:0]      idx;
    logic [DATA_W-1:0]      lut_data;
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] scaled;
    logic [DATA_W-1:0]      sample_q;

    assign idx = acc_q[PHASE_W-1 -: ADDR_W] + phase_off_q[c];

    sine_lut_rom #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .addr  (idx),
      .data  (lut_data)
    );

    assign diff   = $signed({1'b0, lut_data}) - $signed({1'b0, MID});
    assign scaled = diff >>> shift_q[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sample_q <= MID;
      end else if (v1_q) begin
        sample_q <= MID + DATA_W'(scaled);
      end
    end

    assign sample_out[c*DATA_W +: DATA_W] = sample_q;
  end

  assign sample_valid = valid_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_sine_dds_gen.sv
// Bench for sine_dds_gen: table-driven start-up sequence, cycle model with a sample scoreboard,
// and directed sequences for reconfiguration, stop and reset corner cases.
module tb_sine_dds_gen;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int PHASE_W = 8;
  localparam int NUM_CH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  ftw;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ch;
  logic [3:0]  cfg_phase;
  logic [2:0]  cfg_shift;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        wrap;

  always #5 clk = ~clk;

  sine_dds_gen #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W),
    .NUM_CH  (NUM_CH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ftw          (ftw),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_phase    (cfg_phase),
    .cfg_shift    (cfg_shift),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  int checks = 0;
  int errors = 0;

  int lut [16] = '{128, 177, 218, 245, 255, 245, 218, 177, 128, 79, 38, 11, 1, 11, 38, 79};

  // Reference model state
  int          m_acc;
  int          m_phase [2];
  int          m_shift [2];
  int          m_pch, m_pph, m_psh;
  bit          m_pend, m_wrap, m_v1, m_valid;
  logic [15:0] m_last;
  logic [15:0] sb [$];

  typedef struct {
    int exp0;
    int exp1;
    bit ev;
    bit ew;
  } vec_t;

  vec_t vt [18];
  int   seq [18] = '{128, 128, 177, 218, 245, 255, 245, 218, 177, 128, 79, 38, 11, 1, 11, 38, 79, 128};

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int scale(int raw, int sh);
    int d;
    d = raw - 128;
    return (128 + (d >>> sh)) & 255;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_phase = '{0, 0};
    m_shift = '{0, 0};
    m_pend = 0;
    m_pch = 0;
    m_pph = 0;
    m_psh = 0;
    m_wrap = 0;
    m_v1 = 0;
    m_valid = 0;
    m_last = 16'h8080;
    sb.delete();
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    bit          apply;
    int          nphase [2];
    int          nshift [2];
    int          idx;
    logic [15:0] e;
    apply = m_pend && (m_wrap || !en);
    nphase = m_phase;
    nshift = m_shift;
    if (apply && m_pch < NUM_CH) begin
      nphase[m_pch] = m_pph;
      nshift[m_pch] = m_psh;
    end
    if (en) begin
      e = '0;
      for (int c = 0; c < 2; c++) begin
        idx = ((m_acc >> 4) + m_phase[c]) % 16;
        e[c*8 +: 8] = 8'(scale(lut[idx], nshift[c]));
      end
      sb.push_back(e);
    end
    m_valid = m_v1;
    m_v1 = en;
    m_wrap = en && (m_acc + int'(ftw) > 255);
    if (en) m_acc = (m_acc + int'(ftw)) % 256;
    if (apply) begin
      m_pend = 0;
    end else if (cfg_valid && !m_pend) begin
      m_pend = 1;
      m_pch = int'(cfg_ch);
      m_pph = int'(cfg_phase);
      m_psh = int'(cfg_shift);
    end
    m_phase = nphase;
    m_shift = nshift;
  endtask

  task automatic check_outputs();
    check("wrap", int'(wrap), int'(m_wrap));
    check("cfg_ready", int'(cfg_ready), int'(!m_pend));
    check("sample_valid", int'(sample_valid), int'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected a pending sample at %0t", $time);
      end else begin
        m_last = sb.pop_front();
      end
    end
    check("sample_out", int'(sample_out), int'(m_last));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_ready(string name);
    int n;
    n = 0;
    while (!cfg_ready && n < 40) begin
      tick();
      n++;
    end
    check(name, int'(cfg_ready), 1);
  endtask

  task automatic send_cfg(logic ch, logic [3:0] ph, logic [2:0] sh);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_phase = ph;
    cfg_shift = sh;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int mx0, mn0, mx1, mn1, prev0, found, bad;

    for (int i = 0; i < 18; i++) vt[i] = '{seq[i], seq[i], (i > 0), (i == 15)};

    rst_n = 1'b0;
    en = 1'b0;
    ftw = '0;
    cfg_valid = 1'b0;
    cfg_ch = 1'b0;
    cfg_phase = '0;
    cfg_shift = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_sample", int'(sample_out), 16'h8080);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_ready", int'(cfg_ready), 1);

    // Start-up sequence at ftw=16
    en = 1'b1;
    ftw = 8'd16;
    for (int i = 0; i < 18; i++) begin
      tick();
      check("tab_valid", int'(sample_valid), int'(vt[i].ev));
      check("tab_wrap", int'(wrap), int'(vt[i].ew));
      check("tab_ch0", int'(sample_out[7:0]), vt[i].exp0);
      check("tab_ch1", int'(sample_out[15:8]), vt[i].exp1);
    end

    // ch1 phase +4 mid-period
    tick();
    tick();
    send_cfg(1'b1, 4'd4, 3'd0);
    check("phase_pending", int'(cfg_ready), 0);
    wait_ready("phase_applied");
    found = 0;
    prev0 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid && sample_out[7:0] == 8'd128 && prev0 == 79) begin
        found++;
        check("ch1_lead", int'(sample_out[15:8]), 255);
      end
      prev0 = int'(sample_out[7:0]);
    end
    check("lead_seen", (found > 0) ? 1 : 0, 1);

    // ch0 halved amplitude
    tick();
    send_cfg(1'b0, 4'd0, 3'd1);
    wait_ready("shift_applied");
    for (int i = 0; i < 3; i++) tick();
    mx0 = 0; mn0 = 255; mx1 = 0; mn1 = 255;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (int'(sample_out[7:0]) > mx0) mx0 = int'(sample_out[7:0]);
      if (int'(sample_out[7:0]) < mn0) mn0 = int'(sample_out[7:0]);
      if (int'(sample_out[15:8]) > mx1) mx1 = int'(sample_out[15:8]);
      if (int'(sample_out[15:8]) < mn1) mn1 = int'(sample_out[15:8]);
    end
    check("ch0_peak", mx0, 191);
    check("ch0_trough", mn0, 64);
    check("ch1_peak", mx1, 255);
    check("ch1_trough", mn1, 1);

    // Fractional step, then zero step
    ftw = 8'h18;
    for (int i = 0; i < 24; i++) tick();
    ftw = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ftw0_valid", int'(sample_valid), 1);
    end

    // Stop with a pending configuration
    ftw = 8'd16;
    tick();
    send_cfg(1'b1, 4'd4, 3'd7);
    en = 1'b0;
    tick();
    check("stop_apply", int'(cfg_ready), 1);
    tick();
    tick();
    check("stop_drain", int'(sample_valid), 0);
    tick();
    tick();

    // Restart: ch1 shift 7 pins output to MID or MID-1
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid && sample_out[15:8] != 8'd128 && sample_out[15:8] != 8'd127) bad++;
    end
    check("shift7_bad", bad, 0);

    // Transfer during the wrap cycle waits a full period; then reset drops it
    n = 0;
    while (!wrap && n < 40) begin
      tick();
      n++;
    end
    check("wrap_seen", int'(wrap), 1);
    send_cfg(1'b1, 4'd7, 3'd3);
    tick();
    tick();
    check("wrap_cycle_wait", int'(cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sample", int'(sample_out), 16'h8080);
    check("mid_rst_ready", int'(cfg_ready), 1);
    check("mid_rst_valid", int'(sample_valid), 0);
    check("mid_rst_wrap", int'(wrap), 0);
    en = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("lost_ch0", int'(sample_out[7:0]), 245);
    check("lost_ch1", int'(sample_out[15:8]), 245);
    for (int i = 0; i < 12; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
